// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: mode encoding and the
// ONESHOT FSM state enum used by updown_counter_n and mod_step.
package counter_pkg;

    localparam int unsigned MODE_W  = 2;
    localparam int unsigned STATE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    // Counting modes; the reserved code behaves as WRAP.
    localparam mode_t MODE_WRAP    = 2'd0;
    localparam mode_t MODE_SAT     = 2'd1;
    localparam mode_t MODE_ONESHOT = 2'd2;
    localparam mode_t MODE_RSVD    = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Modes that stop at the boundary instead of wrapping around.
    function automatic logic holds_at_boundary(input mode_t mode);
        return (mode == MODE_SAT) || (mode == MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/mod_step.sv
// Combinational next-value unit for one counter stage.
//   cnt_i      current count
//   up_i       direction (1 = increment)
//   mode_i     counting mode (WRAP / SAT / ONESHOT / reserved)
//   din_i      raw load value
//   boundary_o cnt_i sits at the end the counter is heading towards
//   step_val_o value the count takes if a step is applied this cycle
//   reach_o    step_val_o lands on that boundary (ONESHOT terminal)
//   load_val_o din_i clamped to MAX
module mod_step
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic [WIDTH-1:0]  cnt_i,
    input  logic              up_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic [WIDTH-1:0]  din_i,
    output logic              boundary_o,
    output logic [WIDTH-1:0]  step_val_o,
    output logic              reach_o,
    output logic [WIDTH-1:0]  load_val_o
);

    logic [WIDTH-1:0] bound_val;
    logic [WIDTH-1:0] far_val;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;

    // Increment/decrement never cross the boundary, so no natural overflow
    // is relied upon; wrap-around is an explicit select of the far end.
    always_comb begin
        bound_val  = up_i ? MAX : '0;
        far_val    = up_i ? '0  : MAX;
        inc_val    = cnt_i + WIDTH'(1);
        dec_val    = cnt_i - WIDTH'(1);
        boundary_o = (cnt_i == bound_val);
        step_val_o = up_i ? inc_val : dec_val;
        if (boundary_o) begin
            if (holds_at_boundary(mode_t'(mode_i))) begin
                step_val_o = cnt_i;
            end else begin
                step_val_o = far_val;
            end
        end
        reach_o    = (step_val_o == bound_val);
        load_val_o = (din_i > MAX) ? MAX : din_i;
    end

endmodule

// File: rtl/updown_counter_n.sv
// Cascadable up/down counter with wrap, saturate and one-shot modes.
//   clk, rst_n  clock, asynchronous active-low reset
//   en, cin     local and cascade enables; a step needs both
//   up          direction (1 = increment)
//   clr, load   synchronous clear / parallel load (clr wins)
//   din         load value, clamped to MAX
//   mode        0 WRAP, 1 SAT, 2 ONESHOT, 3 reserved (as WRAP)
//   cnt         registered count, 0..MAX
//   rc          combinational ripple carry into the next stage's cin
//   tc          registered one-cycle terminal-event pulse
//   ovf         sticky overflow/underflow flag
//   busy        one-shot run in progress
module updown_counter_n
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cin,
    input  logic              up,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  din,
    input  logic [MODE_W-1:0] mode,
    output logic [WIDTH-1:0]  cnt,
    output logic              rc,
    output logic              tc,
    output logic              ovf,
    output logic              busy
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             tc_q;
    logic             tc_d;

    logic             step_req;
    logic             is_oneshot;
    logic             boundary;
    logic             reach;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_val;

    assign step_req   = en & cin;
    assign is_oneshot = (mode == MODE_ONESHOT);

    mod_step #(
        .WIDTH (WIDTH),
        .MAX   (MAX)
    ) u_step (
        .cnt_i      (cnt_q),
        .up_i       (up),
        .mode_i     (mode),
        .din_i      (din),
        .boundary_o (boundary),
        .step_val_o (step_val),
        .reach_o    (reach),
        .load_val_o (load_val)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE is only reachable in ONESHOT and is left
    // (holding the count) as soon as the mode moves elsewhere.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else if (load) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (step_req) begin
                        state_d = (is_oneshot && reach) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (step_req && is_oneshot && reach) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!is_oneshot) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next values: count, sticky overflow and terminal pulse.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        tc_d  = 1'b0;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            cnt_d = load_val;
            ovf_d = 1'b0;
        end else if (state_q == ST_DONE) begin
            cnt_d = cnt_q;
        end else if (step_req) begin
            cnt_d = step_val;
            if (is_oneshot) begin
                // Arriving at the boundary ends the run; not an overflow.
                tc_d = reach;
            end else if (boundary) begin
                ovf_d = 1'b1;
                tc_d  = 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            tc_q  <= tc_d;
        end
    end

    // Carry is combinational so chained stages step on the same edge.
    assign rc   = cin & en & boundary;
    assign busy = (state_q == ST_RUN) & is_oneshot;
    assign cnt  = cnt_q;
    assign tc   = tc_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_updown_counter_n.sv
module tb_updown_counter_n;
    import counter_pkg::*;

    localparam int unsigned W    = 4;
    localparam int          MAXV = 9;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0, cin = 1'b1, up = 1'b1, clr = 1'b0, load = 1'b0;
    logic [W-1:0] din = '0;
    logic [1:0]   mode = 2'd0;
    logic [W-1:0] cnt;
    logic         rc, tc, ovf, busy;

    logic         c_en = 1'b0;
    logic [W-1:0] lo_cnt, hi_cnt;
    logic         lo_rc, lo_tc, lo_ovf, lo_busy;
    logic         hi_rc, hi_tc, hi_ovf, hi_busy;

    int checks = 0;
    int failures = 0;

    // Behavioural model: count as an integer in 0..MAXV, phase 0 idle/1 run/2 done.
    int m_cnt = 0;
    int m_ph = 0;
    bit m_ovf = 1'b0;
    bit m_tc = 1'b0;

    updown_counter_n #(.WIDTH(W), .MAX(4'd9)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cin(cin), .up(up), .clr(clr),
        .load(load), .din(din), .mode(mode), .cnt(cnt), .rc(rc), .tc(tc),
        .ovf(ovf), .busy(busy)
    );

    updown_counter_n #(.WIDTH(W), .MAX(4'd9)) u_lo (
        .clk(clk), .rst_n(rst_n), .en(c_en), .cin(1'b1), .up(1'b1), .clr(1'b0),
        .load(1'b0), .din(4'd0), .mode(2'd0), .cnt(lo_cnt), .rc(lo_rc), .tc(lo_tc),
        .ovf(lo_ovf), .busy(lo_busy)
    );

    updown_counter_n #(.WIDTH(W), .MAX(4'd9)) u_hi (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .cin(lo_rc), .up(1'b1), .clr(1'b0),
        .load(1'b0), .din(4'd0), .mode(2'd0), .cnt(hi_cnt), .rc(hi_rc), .tc(hi_tc),
        .ovf(hi_ovf), .busy(hi_busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_cnt = 0; m_ph = 0; m_ovf = 1'b0; m_tc = 1'b0;
    endtask

    // One clock of the model, using the inputs as they stand before the edge.
    task automatic model_step();
        int md;
        int bnd;
        md  = (mode == 2'd3) ? 0 : int'(mode);
        bnd = up ? MAXV : 0;
        m_tc = 1'b0;
        if (clr) begin
            m_cnt = 0; m_ovf = 1'b0; m_ph = 0;
        end else if (load) begin
            m_cnt = (int'(din) > MAXV) ? MAXV : int'(din);
            m_ovf = 1'b0; m_ph = 1;
        end else if (m_ph == 2) begin
            if (md != 2) m_ph = 1;
        end else if (en && cin) begin
            if (md == 2) begin
                if (m_cnt != bnd) m_cnt = up ? m_cnt + 1 : m_cnt - 1;
                if (m_cnt == bnd) begin m_tc = 1'b1; m_ph = 2; end
                else m_ph = 1;
            end else if (m_cnt == bnd) begin
                m_ovf = 1'b1; m_tc = 1'b1; m_ph = 1;
                if (md == 0) m_cnt = (m_cnt + (up ? 1 : MAXV)) % (MAXV + 1);
            end else begin
                m_cnt = (m_cnt + (up ? 1 : MAXV)) % (MAXV + 1);
                m_ph = 1;
            end
        end
    endtask

    task automatic tick();
        #1;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0; cin = 1'b1; up = 1'b1; clr = 1'b0; load = 1'b0;
        din = '0; mode = MODE_WRAP; c_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #12;
        checks++; if (cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL reset_tc got=%b exp=0", tc); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_wrap();
        int exp_seq[12];
        int prev;
        exp_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        prev = 0;
        do_reset();
        mode = MODE_WRAP; up = 1'b1; en = 1'b1; cin = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            checks++; if (rc !== (prev == 9)) begin failures++; $display("FAIL wrap_rc i=%0d got=%b exp=%b", i, rc, prev == 9); end
            tick();
            checks++; if (cnt !== 4'(exp_seq[i])) begin failures++; $display("FAIL wrap_cnt i=%0d got=%0d exp=%0d", i, cnt, exp_seq[i]); end
            checks++; if (tc !== (i == 9)) begin failures++; $display("FAIL wrap_tc i=%0d got=%b exp=%b", i, tc, i == 9); end
            checks++; if (ovf !== (i >= 9)) begin failures++; $display("FAIL wrap_ovf i=%0d got=%b exp=%b", i, ovf, i >= 9); end
            prev = exp_seq[i];
        end
    endtask

    task automatic test_sat();
        int exp_seq[4];
        exp_seq = '{1, 0, 0, 0};
        do_reset();
        mode = MODE_SAT; load = 1'b1; din = 4'd2;
        tick();
        checks++; if (cnt !== 4'd2) begin failures++; $display("FAIL sat_load got=%0d exp=2", cnt); end
        load = 1'b0; up = 1'b0; en = 1'b1; cin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (cnt !== 4'(exp_seq[i])) begin failures++; $display("FAIL sat_cnt i=%0d got=%0d exp=%0d", i, cnt, exp_seq[i]); end
            checks++; if (tc !== (i >= 2)) begin failures++; $display("FAIL sat_tc i=%0d got=%b exp=%b", i, tc, i >= 2); end
            checks++; if (ovf !== (i >= 2)) begin failures++; $display("FAIL sat_ovf i=%0d got=%b exp=%b", i, ovf, i >= 2); end
        end
    endtask

    task automatic test_oneshot();
        int exp_seq[7];
        exp_seq = '{4, 3, 2, 1, 0, 0, 0};
        do_reset();
        mode = MODE_ONESHOT; up = 1'b0; load = 1'b1; din = 4'd5;
        tick();
        checks++; if (cnt !== 4'd5 || busy !== 1'b1) begin failures++; $display("FAIL os_load cnt=%0d busy=%b exp cnt=5 busy=1", cnt, busy); end
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (cnt !== 4'(exp_seq[i])) begin failures++; $display("FAIL os_cnt i=%0d got=%0d exp=%0d", i, cnt, exp_seq[i]); end
            checks++; if (tc !== (i == 4)) begin failures++; $display("FAIL os_tc i=%0d got=%b exp=%b", i, tc, i == 4); end
            checks++; if (busy !== (i < 4)) begin failures++; $display("FAIL os_busy i=%0d got=%b exp=%b", i, busy, i < 4); end
            checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL os_ovf i=%0d got=%b exp=0", i, ovf); end
        end
        en = 1'b0; load = 1'b1; din = 4'd3;
        tick();
        load = 1'b0;
        checks++; if (cnt !== 4'd3 || busy !== 1'b1) begin failures++; $display("FAIL os_reload cnt=%0d busy=%b exp cnt=3 busy=1", cnt, busy); end
    endtask

    task automatic test_clamp_clr();
        do_reset();
        mode = MODE_WRAP; load = 1'b1; din = 4'd15;
        tick();
        checks++; if (cnt !== 4'd9) begin failures++; $display("FAIL clamp_cnt got=%0d exp=9", cnt); end
        clr = 1'b1; load = 1'b1; din = 4'd4; mode = MODE_ONESHOT;
        tick();
        checks++; if (cnt !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin failures++; $display("FAIL clrload cnt=%0d busy=%b tc=%b exp 0/0/0", cnt, busy, tc); end
        clr = 1'b0; load = 1'b0; en = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
        en = 1'b1; up = 1'b1;
        tick();
        checks++; if (cnt !== 4'd1 || busy !== 1'b1) begin failures++; $display("FAIL idle_step cnt=%0d busy=%b exp cnt=1 busy=1", cnt, busy); end
    endtask

    task automatic test_mode_change();
        do_reset();
        mode = MODE_ONESHOT; up = 1'b1; load = 1'b1; din = 4'd8;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        checks++; if (cnt !== 4'd9 || tc !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mc_done cnt=%0d tc=%b busy=%b exp 9/1/0", cnt, tc, busy); end
        tick();
        checks++; if (cnt !== 4'd9 || tc !== 1'b0) begin failures++; $display("FAIL mc_hold cnt=%0d tc=%b exp 9/0", cnt, tc); end
        mode = MODE_WRAP;
        tick();
        checks++; if (cnt !== 4'd9 || tc !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL mc_leave cnt=%0d tc=%b ovf=%b exp 9/0/0", cnt, tc, ovf); end
        #1;
        checks++; if (rc !== 1'b1) begin failures++; $display("FAIL mc_rc got=%b exp=1", rc); end
        tick();
        checks++; if (cnt !== 4'd0 || tc !== 1'b1 || ovf !== 1'b1) begin failures++; $display("FAIL mc_wrap cnt=%0d tc=%b ovf=%b exp 0/1/1", cnt, tc, ovf); end
    endtask

    task automatic test_cascade();
        int v;
        do_reset();
        c_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            checks++; if (hi_rc !== (i == 99)) begin failures++; $display("FAIL casc_rc i=%0d got=%b exp=%b", i, hi_rc, i == 99); end
            tick();
            v = (i + 1) % 100;
            checks++; if (lo_cnt !== 4'(v % 10) || hi_cnt !== 4'(v / 10)) begin failures++; $display("FAIL casc_bcd i=%0d got=%0d%0d exp=%0d", i, hi_cnt, lo_cnt, v); end
            checks++; if (lo_tc !== (v % 10 == 0) || hi_tc !== (v == 0)) begin failures++; $display("FAIL casc_tc i=%0d lo=%b hi=%b", i, lo_tc, hi_tc); end
            checks++; if ((lo_busy | hi_busy) !== 1'b0) begin failures++; $display("FAIL casc_busy i=%0d got=%b exp=0", i, lo_busy | hi_busy); end
        end
        c_en = 1'b0;
        checks++; if (lo_ovf !== 1'b1 || hi_ovf !== 1'b1) begin failures++; $display("FAIL casc_ovf lo=%b hi=%b exp 1/1", lo_ovf, hi_ovf); end
    endtask

    task automatic test_async_reset();
        do_reset();
        mode = MODE_WRAP; up = 1'b1; load = 1'b1; din = 4'd9; en = 1'b1;
        tick();
        load = 1'b0;
        tick();
        checks++; if (tc !== 1'b1) begin failures++; $display("FAIL ar_pre_tc got=%b exp=1", tc); end
        #3; rst_n = 1'b0; #1;
        model_reset();
        checks++; if (tc !== 1'b0 || ovf !== 1'b0 || cnt !== 4'd0) begin failures++; $display("FAIL ar_tc_drop tc=%b ovf=%b cnt=%0d exp 0/0/0", tc, ovf, cnt); end
        #2; rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (cnt !== 4'd6) begin failures++; $display("FAIL ar_pre_cnt got=%0d exp=6", cnt); end
        #3; rst_n = 1'b0; #1;
        model_reset();
        checks++; if (cnt !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ar_mid cnt=%0d tc=%b busy=%b exp 0/0/0", cnt, tc, busy); end
        #2; rst_n = 1'b1;
        tick();
        checks++; if (cnt !== 4'd1) begin failures++; $display("FAIL ar_resume got=%0d exp=1", cnt); end
    endtask

    task automatic test_random();
        bit exp_rc;
        do_reset();
        cin = 1'b1; en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) up = ~up;
            en   = ($urandom_range(0, 3) != 0);
            cin  = ($urandom_range(0, 7) != 0);
            clr  = ($urandom_range(0, 31) == 0);
            load = ($urandom_range(0, 11) == 0);
            din  = 4'($urandom_range(0, 15));
            #1;
            exp_rc = en && cin && (m_cnt == (up ? MAXV : 0));
            checks++; if (rc !== exp_rc) begin failures++; $display("FAIL rnd_rc i=%0d got=%b exp=%b", i, rc, exp_rc); end
            tick();
            checks++; if (cnt !== 4'(m_cnt)) begin failures++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, cnt, m_cnt); end
            checks++; if (tc !== m_tc) begin failures++; $display("FAIL rnd_tc i=%0d got=%b exp=%b", i, tc, m_tc); end
            checks++; if (ovf !== m_ovf) begin failures++; $display("FAIL rnd_ovf i=%0d got=%b exp=%b", i, ovf, m_ovf); end
            checks++; if (busy !== (m_ph == 1 && mode == 2'd2)) begin failures++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, busy, m_ph == 1 && mode == 2'd2); end
        end
        clr = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_sat();
        test_oneshot();
        test_clamp_clr();
        test_mode_change();
        test_cascade();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updown_counter_n.md
UPDOWN_COUNTER_N -- requirements
Module: updown_counter_n

Interface
REQ-001 Parameter WIDTH, default 16: counter width in bits, legal range 2..32.
REQ-002 Parameter MAX, default 2**WIDTH-1: terminal count value; count range is 0..MAX; legal range 1..2**WIDTH-1.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 en  in  1  local count enable.
REQ-006 cin  in  1  cascade enable from the previous stage's rc; tie to 1 when not cascaded.
REQ-007 up  in  1  direction: 1 = increment, 0 = decrement.
REQ-008 clr  in  1  synchronous clear.
REQ-009 load  in  1  synchronous parallel load.
REQ-010 din  in  WIDTH  load value.
REQ-011 mode  in  2  0 = WRAP, 1 = SAT, 2 = ONESHOT, 3 = reserved (behaves as WRAP).
REQ-012 cnt  out  WIDTH  current count, registered.
REQ-013 rc  out  1  combinational ripple carry for cascading.
REQ-014 tc  out  1  registered one-cycle terminal-event pulse.
REQ-015 ovf  out  1  sticky overflow/underflow flag.
REQ-016 busy  out  1  high while ONESHOT is in RUN.

Function
REQ-017 A step is requested when en & cin are both 1; its target is cnt+1 if up = 1, else cnt-1.
REQ-018 Per-cycle priority is clr > load > step > hold.
REQ-019 clr sets cnt=0, ovf=0 and state=IDLE, with tc=0 in the next cycle.
REQ-020 load sets cnt=din, clamped to MAX when din > MAX, clears ovf, and sets state=RUN.
REQ-021 Boundary is defined as cnt==MAX when up = 1, and cnt==0 when up = 0.
REQ-022 rc = cin & en & boundary, evaluated combinationally from current cnt, up, cin and en, so that chained stages step together.
REQ-023 WRAP: a step at the boundary sets cnt to the opposite end (MAX→0 up, 0→MAX down), sets ovf, and pulses tc.
REQ-024 SAT: a step at the boundary leaves cnt unchanged, sets ovf, and pulses tc on every such attempted step.
REQ-025 ONESHOT uses a three-state FSM: IDLE, RUN, DONE.
REQ-026 ONESHOT IDLE→RUN on load or on the first step; the step is applied in that same cycle.
REQ-027 ONESHOT RUN→DONE when a step makes cnt equal to the boundary; tc pulses and ovf is not set.
REQ-028 ONESHOT DONE ignores steps and holds cnt; it exits only via load (→RUN) or clr (→IDLE).
REQ-029 In WRAP and SAT the FSM is never in DONE; the first step or load moves IDLE→RUN.
REQ-030 If mode changes away from ONESHOT while in DONE, state becomes RUN on the next edge and cnt is unchanged.
REQ-031 busy = (state==RUN) & (mode==ONESHOT).
REQ-032 tc is high for exactly one cycle, in the cycle after the triggering edge; it never stays high across consecutive cycles unless a new event occurs.
REQ-033 A direction change mid-count takes effect on the next step; no extra cycle or skipped value is allowed.
REQ-034 All arithmetic is WIDTH bits, with wrap handled explicitly against MAX, never by natural overflow, so non-power-of-two MAX is exact.

Reset
REQ-035 rst_n low immediately forces cnt=0, tc=0, ovf=0, busy=0 and state=IDLE, independent of clk.
REQ-036 On rst_n deassertion, the first step is taken on the first rising edge at which rst_n is high.
REQ-037 Reset mid-count discards the count and any pending tc.

Structure
REQ-038 A shared package counter_pkg holds the mode encoding constants and the FSM state enum (IDLE, RUN, DONE).
REQ-039 Next-value computation (step, boundary detect, wrap/saturate select) is one combinational sub-module, mod_step, parametrised by WIDTH and MAX.
REQ-040 The top level holds only registers, the FSM, and the rc/busy logic.

Verification
REQ-041 WIDTH=4, MAX=9, WRAP, up=1, en=cin=1 for 12 cycles from reset → cnt 1..9,0,1,2; tc and ovf set after 9→0; rc high while cnt==9.
REQ-042 WIDTH=4, MAX=9, SAT, up=0 from cnt=2 for 4 cycles → cnt 1,0,0,0; tc pulses twice (each attempted step at 0); ovf=1.
REQ-043 ONESHOT: load din=5, up=0, then 7 step cycles → cnt 4..0 then holds 0; busy falls and tc pulses once when cnt reaches 0; load din=3 resumes RUN.
REQ-044 load with din=15 at MAX=9 → cnt=9; assert clr and load together → cnt=0, state IDLE.
REQ-045 Two instances cascaded (rc→cin), WIDTH=4, MAX=9, up=1 → upper stage increments only on lower 9→0; 100 steps read as BCD 00 after 99.
REQ-046 rst_n pulsed low asynchronously mid-cycle at cnt=6 → cnt=0, tc=0 before the next clk edge; counting resumes from 0.
